// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern-mode encodings, the colour-bar table and
// the default 640x480@60 timing so every block instantiates consistently.
package vga_pkg;

  // Default 640x480@60 timing (pixels / lines).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_COLOR_W  = 4;
  localparam int DEF_CNT_W    = 11;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  // Colour-bar table as {r,g,b} on/off flags, left to right:
  // white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: h/v counters, region decode, registered sync/de/x/y
// and the frame_start pulse. The raw counters and the active-region flag are
// also exported so the pattern stage can register its colour on the same edge.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START  = H_ACTIVE + H_FP;
  localparam int HS_END    = HS_START + H_SYNC;
  localparam int VS_START  = V_ACTIVE + V_FP;
  localparam int VS_END    = VS_START + V_SYNC;

  logic h_last;
  logic v_last;
  logic h_active;
  logic v_active;
  logic hs_on;
  logic vs_on;
  logic origin;

  // Decode wrap points and display regions from the current counter values.
  always_comb begin
    h_last   = (h_cnt == CNT_W'(H_TOTAL - 1));
    v_last   = (v_cnt == CNT_W'(V_TOTAL - 1));
    h_active = (h_cnt <  CNT_W'(H_ACTIVE));
    v_active = (v_cnt <  CNT_W'(V_ACTIVE));
    hs_on    = (h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END));
    vs_on    = (v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END));
    origin   = (h_cnt == '0) && (v_cnt == '0);
    active   = h_active && v_active;
  end

  // Raster counters: h wraps every line, v steps on each h wrap.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Register the decoded regions so they line up with the pattern registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      // Cleared on disabled cycles so the pulse is always exactly one clk.
      frame_start <= pix_en && origin;
      if (pix_en) begin
        hsync <= hs_on ? HS_POL : ~HS_POL;
        vsync <= vs_on ? VS_POL : ~VS_POL;
        de    <= active;
        x     <= h_cnt;
        y     <= v_cnt;
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: timing core plus frame-synchronous mode latch,
// pattern mux and registered colour outputs aligned with sync/de/x/y.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = DEF_COLOR_W,
  parameter int   CNT_W    = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_en,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [CNT_W-1:0]     x,
  output logic [CNT_W-1:0]     y,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 frame_start,
  output logic [7:0]           frame_cnt
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  logic               active;
  logic               origin;
  mode_t              mode_q;
  mode_t              mode_eff;
  logic [CNT_W-1:0]   bar_idx;
  logic [2:0]         bar_rgb;
  logic [COLOR_W-1:0] red_d;
  logic [COLOR_W-1:0] green_d;
  logic [COLOR_W-1:0] blue_d;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL),
    .CNT_W    (CNT_W)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .frame_start (frame_start)
  );

  // The first pixel of a frame already uses the newly sampled mode, so a
  // mode change never splits a frame.
  always_comb begin
    origin   = (h_cnt == '0) && (v_cnt == '0);
    mode_eff = origin ? mode_t'(mode) : mode_q;
  end

  // Pattern mux for the pixel the counters currently point at.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path through
    // the case can leave a value unassigned and infer a latch.
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    bar_idx = h_cnt / CNT_W'(BAR_W);
    bar_rgb = bar_color(bar_idx[2:0]);
    if (active) begin
      case (mode_eff)
        MODE_BARS: begin
          // Remainder pixels past the eighth bar stay black.
          if (bar_idx < CNT_W'(8)) begin
            red_d   = {COLOR_W{bar_rgb[2]}};
            green_d = {COLOR_W{bar_rgb[1]}};
            blue_d  = {COLOR_W{bar_rgb[0]}};
          end
        end
        MODE_CHECK: begin
          if (!(h_cnt[5] ^ v_cnt[5])) begin
            red_d   = '1;
            green_d = '1;
            blue_d  = '1;
          end
        end
        MODE_GRAD: begin
          red_d   = h_cnt[COLOR_W+4:5];
          green_d = h_cnt[COLOR_W+4:5];
          blue_d  = h_cnt[COLOR_W+4:5];
        end
        MODE_SOLID: begin
          red_d   = solid_rgb[3*COLOR_W-1 -: COLOR_W];
          green_d = solid_rgb[2*COLOR_W-1 -: COLOR_W];
          blue_d  = solid_rgb[COLOR_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // Mode latch, frame counter and colour output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_BARS;
      frame_cnt <= '0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else if (pix_en) begin
      if (origin) begin
        mode_q    <= mode_t'(mode);
        frame_cnt <= frame_cnt + 8'd1;
      end
      red   <= red_d;
      green <= green_d;
      blue  <= blue_d;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen. A scaled-down raster instance is
// compared cycle by cycle with a position-based reference model; three more
// instances cover default 640x480 sync timing and bars, active-high hsync
// with H_ACTIVE=800, and frame counter wrap on a tiny raster.
`timescale 1ns/1ps
module tb_vga_pattern_gen;

  localparam int CW = 4;
  localparam int NW = 11;

  // Scaled raster for the scoreboarded instance (wide enough for x=512).
  localparam int SH_A = 524, SH_FP = 4, SH_S = 8, SH_BP = 4;
  localparam int SV_A = 34,  SV_FP = 1, SV_S = 2, SV_BP = 2;
  localparam int HT    = SH_A + SH_FP + SH_S + SH_BP;
  localparam int VT    = SV_A + SV_FP + SV_S + SV_BP;
  localparam int FRAME = HT * VT;

  localparam logic [11:0] BAR_REF [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                          12'hF0F, 12'hF00, 12'h00F, 12'h000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboarded instance ----------------
  logic          rst, pix_en;
  logic [1:0]    mode;
  logic [11:0]   solid;
  logic          hs, vs, de, fs;
  logic [NW-1:0] x, y;
  logic [CW-1:0] r, g, b;
  logic [7:0]    fc;

  vga_pattern_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(CW), .CNT_W(NW)
  ) u_sm (
    .clk(clk), .rst(rst), .pix_en(pix_en), .mode(mode), .solid_rgb(solid),
    .hsync(hs), .vsync(vs), .de(de), .x(x), .y(y),
    .red(r), .green(g), .blue(b), .frame_start(fs), .frame_cnt(fc)
  );

  // ---------------- free-running auxiliary instances ----------------
  logic        rst_aux;
  logic        en_aux    = 1'b1;
  logic [1:0]  mode_aux  = 2'd0;
  logic [11:0] solid_aux = 12'h000;

  logic d_hs, d_vs, d_de, d_fs; logic [NW-1:0] d_x, d_y;
  logic [CW-1:0] d_r, d_g, d_b; logic [7:0] d_fc;
  vga_pattern_gen u_def (
    .clk(clk), .rst(rst_aux), .pix_en(en_aux), .mode(mode_aux), .solid_rgb(solid_aux),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y),
    .red(d_r), .green(d_g), .blue(d_b), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  logic h_hs, h_vs, h_de, h_fs; logic [NW-1:0] h_x, h_y;
  logic [CW-1:0] h_r, h_g, h_b; logic [7:0] h_fc;
  vga_pattern_gen #(.H_ACTIVE(800), .HS_POL(1'b1)) u_hi (
    .clk(clk), .rst(rst_aux), .pix_en(en_aux), .mode(mode_aux), .solid_rgb(solid_aux),
    .hsync(h_hs), .vsync(h_vs), .de(h_de), .x(h_x), .y(h_y),
    .red(h_r), .green(h_g), .blue(h_b), .frame_start(h_fs), .frame_cnt(h_fc)
  );

  logic t_hs, t_vs, t_de, t_fs; logic [NW-1:0] t_x, t_y;
  logic [CW-1:0] t_r, t_g, t_b; logic [7:0] t_fc;
  vga_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_tiny (
    .clk(clk), .rst(rst_aux), .pix_en(en_aux), .mode(mode_aux), .solid_rgb(solid_aux),
    .hsync(t_hs), .vsync(t_vs), .de(t_de), .x(t_x), .y(t_y),
    .red(t_r), .green(t_g), .blue(t_b), .frame_start(t_fs), .frame_cnt(t_fc)
  );

  // Auxiliary monitors: aux_pe counts clk edges since rst_aux release.
  int aux_pe = 0;
  always @(posedge clk) aux_pe <= rst_aux ? 0 : aux_pe + 1;

  int          d_fall[$], d_rise[$], h_rise[$], h_fall[$];
  logic        d_hs_prev = 1'b1, h_hs_prev = 1'b0, t_fs_prev = 1'b0;
  logic [11:0] d_line10 [640];
  int          d_blank_bad = 0, t_fs_n = 0, t_fs_double = 0;
  logic [8:0]  t_fc_255 = 9'h1FF, t_fc_256 = 9'h1FF;

  always @(negedge clk) begin
    if (!rst_aux) begin
      if (d_hs_prev && !d_hs) d_fall.push_back(aux_pe);
      if (!d_hs_prev && d_hs) d_rise.push_back(aux_pe);
      d_hs_prev = d_hs;
      if (d_de && d_y == 10) d_line10[d_x] = {d_r, d_g, d_b};
      if (!d_de && {d_r, d_g, d_b} != 12'h000) d_blank_bad++;
      if (!h_hs_prev && h_hs) h_rise.push_back(aux_pe);
      if (h_hs_prev && !h_hs) h_fall.push_back(aux_pe);
      h_hs_prev = h_hs;
      if (t_fs) begin
        t_fs_n++;
        if (t_fs_prev) t_fs_double++;
        if (t_fs_n == 255) t_fc_255 = {1'b0, t_fc};
        if (t_fs_n == 256) t_fc_256 = {1'b0, t_fc};
      end
      t_fs_prev = t_fs;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pos = enabled pixel steps since reset, modulo the frame.
  int          pos = 0;
  logic [1:0]  mq = 2'd0;
  logic [7:0]  m_fc = 8'd0;
  logic        e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0;
  int          e_x = 0, e_y = 0;
  logic [11:0] e_rgb = 12'h000;
  int          cyc = 0, rel_cyc = 0;
  int          fs_t[$], hs_fall[$], vs_fall[$], vs_rise[$];
  logic        prev_hs = 1'b1, prev_vs = 1'b1;
  logic        rnd_en = 1'b0;

  function automatic logic [11:0] ref_pix(input int h, input int v,
                                          input logic [1:0] m, input logic [11:0] s);
    int k;
    int gl;
    if (h >= SH_A || v >= SV_A) return 12'h000;
    case (m)
      2'd0: begin
        k = h / (SH_A / 8);
        return (k < 8) ? BAR_REF[k] : 12'h000;
      end
      2'd1: return ((((h / 32) + (v / 32)) % 2) == 0) ? 12'hFFF : 12'h000;
      2'd2: begin
        gl = (h / 32) % 16;
        return {gl[3:0], gl[3:0], gl[3:0]};
      end
      default: return s;
    endcase
  endfunction

  // Advance model and DUT by one clk using the currently driven inputs,
  // then compare on the falling edge.
  task automatic tick();
    int h, v;
    if (rst) begin
      pos = 0; mq = 2'd0; m_fc = 8'd0;
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0;
      e_x = 0; e_y = 0; e_rgb = 12'h000;
    end else begin
      e_fs = pix_en && (pos == 0);
      if (pix_en) begin
        h = pos % HT;
        v = pos / HT;
        if (pos == 0) begin
          mq = mode;
          m_fc = m_fc + 8'd1;
        end
        e_hs  = !(h >= SH_A + SH_FP && h < SH_A + SH_FP + SH_S);
        e_vs  = !(v >= SV_A + SV_FP && v < SV_A + SV_FP + SV_S);
        e_de  = (h < SH_A) && (v < SV_A);
        e_x   = h;
        e_y   = v;
        e_rgb = ref_pix(h, v, mq, solid);
        pos   = (pos + 1) % FRAME;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (bad < 20) begin
      check("sync_de_fs_cnt", {hs, vs, de, fs, fc}, {e_hs, e_vs, e_de, e_fs, m_fc});
      check("rgb", {r, g, b}, e_rgb);
      if (e_de) check("xy", {x, y}, {NW'(e_x), NW'(e_y)});
    end
    if (fs) fs_t.push_back(cyc);
    if (prev_hs && !hs) hs_fall.push_back(cyc);
    if (prev_vs && !vs) vs_fall.push_back(cyc);
    if (!prev_vs && vs) vs_rise.push_back(cyc);
    prev_hs = hs;
    prev_vs = vs;
  endtask

  // Step until the model points at (h,v), then one enabled step so the
  // outputs present that pixel.
  task automatic goto(input int h, input int v);
    int target;
    int guard;
    target = v * HT + h;
    guard  = 0;
    while (pos != target && guard < 4 * FRAME) begin
      pix_en = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      guard++;
    end
    pix_en = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; mode = 2'd0; solid = 12'h000; rst_aux = 1'b1;
    tick();
    tick();
    check("rst_hsync", hs, 1'b1);
    check("rst_vsync", vs, 1'b1);
    check("rst_de_fs", {de, fs}, 2'b00);
    check("rst_rgb", {r, g, b}, 12'h000);
    check("rst_fc", fc, 8'd0);
    check("rst_hi_hsync_pol1", h_hs, 1'b0);

    // Phase A: bars with a mid-frame switch to solid colour.
    rst = 1'b0; rst_aux = 1'b0; pix_en = 1'b1;
    rel_cyc = cyc;
    fs_t.delete(); hs_fall.delete(); vs_fall.delete(); vs_rise.delete();
    while (pos != 20 * HT) tick();
    mode = 2'd3; solid = 12'hA5C;
    while (pos != 0) tick();
    tick();
    check("switch_first_pix_rgb", {r, g, b}, 12'hA5C);
    check("switch_first_pix_fs", fs, 1'b1);
    check("frame_cnt_two_frames", fc, 8'd2);
    check("sm_event_counts_ok", int'(hs_fall.size() >= 2 && vs_fall.size() >= 1 &&
                                     vs_rise.size() >= 1 && fs_t.size() >= 2), 1);
    if (hs_fall.size() >= 2 && vs_fall.size() >= 1 && vs_rise.size() >= 1 && fs_t.size() >= 2) begin
      check("sm_hs_first_fall", hs_fall[0] - rel_cyc, SH_A + SH_FP + 1);
      check("sm_hs_period", hs_fall[1] - hs_fall[0], HT);
      check("sm_vs_width", vs_rise[0] - vs_fall[0], SV_S * HT);
      check("sm_frame_period", fs_t[1] - fs_t[0], FRAME);
    end

    // Phase B: mid-frame reset with pix_en low, then checker and toggling.
    while (pos != 12 * HT + 100) tick();
    rst = 1'b1; pix_en = 1'b0;
    tick();
    check("midrst_sync", {hs, vs}, 2'b11);
    check("midrst_de", de, 1'b0);
    check("midrst_fc", fc, 8'd0);
    rst = 1'b0; mode = 2'd1;
    goto(31, 0);
    check("check_31_0_white", {r, g, b}, 12'hFFF);
    tick();
    check("check_32_0_black", {r, g, b}, 12'h000);
    hs_fall.delete();
    for (int i = 0; i < 4 * HT; i++) begin
      pix_en = (i % 2 == 0);
      tick();
    end
    check("toggle_hs_events_ok", int'(hs_fall.size() >= 2), 1);
    if (hs_fall.size() >= 2) check("toggle_line_period", hs_fall[1] - hs_fall[0], 2 * HT);
    goto(32, 32);
    check("check_32_32_white", {r, g, b}, 12'hFFF);

    // Phase C: gradient with random pix_en; frame_start width under toggling.
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 2'd2; pix_en = 1'b1;
    tick();
    check("fs_toggle_high", fs, 1'b1);
    pix_en = 1'b0;
    tick();
    check("fs_toggle_low", fs, 1'b0);
    rnd_en = 1'b1;
    goto(0, 3);
    check("grad_x0", {r, g, b}, 12'h000);
    goto(32, 3);
    check("grad_x32", {r, g, b}, 12'h111);
    goto(511, 3);
    check("grad_x511", {r, g, b}, 12'hFFF);
    tick();
    check("grad_x512", {r, g, b}, 12'h000);

    // Phase D: random solid colour every pixel, random enables and modes.
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 2'd3;
    for (int i = 0; i < 1500; i++) begin
      pix_en = ($urandom_range(0, 3) != 0);
      solid  = 12'($urandom);
      if (i > 200) mode = 2'($urandom_range(0, 3));
      tick();
    end

    // Auxiliary instances: default timing, bars on line 10, polarity, wrap.
    for (int i = 0; i < 40000 && t_fs_n < 257; i++) @(negedge clk);
    check("def_hs_events_ok", int'(d_fall.size() >= 2 && d_rise.size() >= 1), 1);
    if (d_fall.size() >= 2 && d_rise.size() >= 1) begin
      check("def_hs_first_fall_657", d_fall[0], 657);
      check("def_hs_width_96", d_rise[0] - d_fall[0], 96);
      check("def_hs_period_800", d_fall[1] - d_fall[0], 800);
    end
    for (int k = 0; k < 8; k++) begin
      check("def_bar_left", d_line10[k * 80], BAR_REF[k]);
      check("def_bar_right", d_line10[k * 80 + 79], BAR_REF[k]);
    end
    check("def_blank_rgb_zero", d_blank_bad, 0);
    check("hi_hs_events_ok", int'(h_rise.size() >= 1 && h_fall.size() >= 1), 1);
    if (h_rise.size() >= 1 && h_fall.size() >= 1) begin
      check("hi_hs_rise_at_816", h_rise[0], 800 + 16 + 1);
      check("hi_hs_width", h_fall[0] - h_rise[0], 96);
    end
    check("tiny_fc_at_255", t_fc_255, 9'd255);
    check("tiny_fc_wrap_256", t_fc_256, 9'd0);
    check("tiny_fs_single_clk", t_fs_double, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
